// File: rtl/seg_carry_sum_finalizer.sv
// Multi-cycle final adder: resolves the two compressor-tree rows SEG bits per cycle,
// carrying between segments through a register, with valid/ready on both sides.
module seg_carry_sum_finalizer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned SegSafe = (SEG > 0) ? SEG : 1;
  localparam int unsigned NSEG    = WIDTH / SegSafe;
  localparam int unsigned IdxW    = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSEG - 1);

  if ((SEG < 1) || (WIDTH % SegSafe != 0)) begin : gen_param_check
    $error("seg_carry_sum_finalizer: WIDTH must be a nonzero multiple of SEG");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d, out_valid_q, out_valid_d;
  logic [IdxW-1:0]   seg_idx_q, seg_idx_d;

  int                seg_base;
  logic [SEG-1:0]    a_seg, b_seg, g, p, pre_g, pre_p, c, seg_sum;
  logic [SEG:0]      cvec;
  logic              grp_cout;

  // Segment datapath: group (G,P) prefix per bit position, then apply the incoming carry.
  always_comb begin
    seg_base = int'(seg_idx_q) * int'(SEG);
    a_seg    = a_q[seg_base +: SEG];
    b_seg    = b_q[seg_base +: SEG];
    g        = a_seg & b_seg;
    p        = a_seg ^ b_seg;
    pre_g    = '0;
    pre_p    = '0;
    pre_g[0] = g[0];
    pre_p[0] = p[0];
    for (int i = 1; i < int'(SEG); i++) begin
      pre_g[i] = g[i] | (p[i] & pre_g[i-1]);
      pre_p[i] = p[i] & pre_p[i-1];
    end
    c        = pre_g | (pre_p & {SEG{carry_q}});
    cvec     = {c, carry_q};
    seg_sum  = p ^ cvec[SEG-1:0];
    grp_cout = c[SEG-1];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    seg_idx_d   = seg_idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = row_a;
          b_d       = row_b;
          carry_d   = cin;
          seg_idx_d = '0;
          sum_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        sum_d[seg_base +: SEG] = seg_sum;
        carry_d = grp_cout;
        if (seg_idx_q == LastIdx) begin
          seg_idx_d   = '0;
          cout_d      = grp_cout;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          seg_idx_d = seg_idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      seg_idx_q   <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      seg_idx_q   <= seg_idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_seg_carry_sum_finalizer.sv
// Bench for seg_carry_sum_finalizer: transaction-level reference model checked every cycle,
// directed literal cases, backpressure, mid-run reset, an NSEG==1 instance and streaming.
module tb_seg_carry_sum_finalizer;
  localparam int NSEG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [31:0] row_a, row_b, sum;

  logic        n_valid, n_ready, n_cin, n_ovalid, n_cout, n_busy;
  logic [7:0]  n_a, n_b, n_sum;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_carry_sum_finalizer #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .row_a(row_a), .row_b(row_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  seg_carry_sum_finalizer #(.WIDTH(8), .SEG(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_ready),
    .row_a(n_a), .row_b(n_b), .cin(n_cin), .out_valid(n_ovalid),
    .out_ready(1'b1), .sum(n_sum), .cout(n_cout), .busy(n_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a result is plain a+b+cin, visible NSEG edges after acceptance.
  typedef enum int {MIdle, MRun, MDone} mph_e;
  mph_e        mph   = MIdle;
  int          mcnt  = 0;
  logic [32:0] mexp  = '0;
  logic [32:0] mlast = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph   <= MIdle;
      mcnt  <= 0;
      mexp  <= '0;
      mlast <= '0;
    end else begin
      case (mph)
        MIdle: if (in_valid) begin
          mexp <= {1'b0, row_a} + {1'b0, row_b} + 33'(cin);
          mcnt <= NSEG;
          mph  <= MRun;
        end
        MRun: if (mcnt == 1) mph <= MDone; else mcnt <= mcnt - 1;
        MDone: if (out_ready) begin
          mph   <= MIdle;
          mlast <= mexp;
        end
        default: mph <= MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(mph == MIdle));
    chk("busy", 64'(busy), 64'(mph != MIdle));
    chk("out_valid", 64'(out_valid), 64'(mph == MDone));
    if (mph == MDone) chk("result", 64'({cout, sum}), 64'(mexp));
    if (mph == MIdle) chk("held_result", 64'({cout, sum}), 64'(mlast));
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(posedge clk); #1;
    row_a = a; row_b = b; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [32:0] lit);
    int edges;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({name, "_latency"}, 64'(edges), 64'(NSEG));
    chk({name, "_sum"}, 64'({cout, sum}), 64'(lit));
    chk({name, "_model"}, 64'(mexp), 64'(lit));
  endtask

  task automatic xact(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [32:0] lit);
    out_ready = 1'b1;
    start(a, b, c);
    wait_result(name, lit);
    @(posedge clk); #1;
    chk({name, "_release_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_release_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] s_hold;
    logic        c_hold;
    int          last_cyc, guard;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    row_a = '0; row_b = '0; cin = 1'b0;
    n_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    xact("basic", 32'h12345678, 32'h87654321, 1'b0, 33'h0_99999999);
    xact("ripple_b", 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000);
    xact("ripple_cin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
    xact("zero_cin", 32'h00000000, 32'h00000000, 1'b1, 33'h0_00000001);

    // Backpressure with a stray in_valid pulse while DONE.
    out_ready = 1'b0;
    start(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
    wait_result("bp", 33'h1_00000000);
    s_hold = sum; c_hold = cout;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 1);
      if (i == 1) row_a = 32'h0BADF00D;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum), 64'(s_hold));
      chk("bp_cout", 64'(cout), 64'(c_hold));
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);

    // Reset two segments into an all-propagate operation.
    start(32'hFFFFFFFF, 32'h00000001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_still_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    xact("after_rst", 32'h0000FFFF, 32'h00000001, 1'b1, 33'h0_00010001);

    // NSEG==1: one RUN cycle.
    @(posedge clk); #1;
    n_a = 8'hFF; n_b = 8'h01; n_cin = 1'b0; n_valid = 1'b1;
    @(posedge clk); #1;
    n_valid = 1'b0;
    chk("n1_busy", 64'(n_busy), 64'd1);
    chk("n1_not_yet", 64'(n_ovalid), 64'd0);
    @(posedge clk); #1;
    chk("n1_valid", 64'(n_ovalid), 64'd1);
    chk("n1_sum", 64'({n_cout, n_sum}), 64'h100);
    @(posedge clk); #1;
    chk("n1_idle", 64'(n_ready), 64'd1);

    // Streaming with both handshakes tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_cyc  = 0;
    for (int k = 0; k < 10000; k++) begin
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 20) chk("stream_timeout", 64'd1, 64'd0);
      if (k > 0) chk("stream_period", 64'(cyc - last_cyc), 64'(NSEG + 2));
      last_cyc = cyc;
      row_a = $urandom;
      row_b = (k % 16 == 0) ? ~row_a : $urandom;
      cin   = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_carry_sum_finalizer.md
Name: seg_carry_sum_finalizer

Overview:
- Sequential final-addition back end for the compressor-tree / prefix-tree multiplier flow.
- Consumes the two residual rows produced by the compressor tree and resolves carries with a per-segment generate/propagate prefix.
- Produces the final WIDTH-bit sum plus carry-out over WIDTH/SEG cycles.
- Trades latency for area against the fully combinational prefix tree; uses valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per cycle; NSEG = WIDTH/SEG.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  row_a/row_b/cin valid.
- in_ready  output  1  block can accept operands.
- row_a  input  WIDTH  first residual row.
- row_b  input  WIDTH  second residual row.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  final sum, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (rst_n low, immediate): state=IDLE, sum=0, cout=0, out_valid=0, busy=0, carry register=0, segment counter=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a clock edge: capture row_a, row_b; carry<=cin; seg_idx<=0; sum<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, operate on bits [seg_idx*SEG +: SEG]:
    - g=a&b, p=a^b.
    - Intra-segment carries come from a prefix combine with operator (g1,p1)o(g2,p2) = (g2|p2&g1, p1&p2), seeded with the carry register.
    - Segment sum = p ^ {c[SEG-2:0], carry}.
  - At the edge: write the segment into sum; carry<=group carry out; seg_idx<=seg_idx+1.
  - When seg_idx==NSEG-1: cout<=group carry out, out_valid<=1, go to DONE.
- DONE:
  - out_valid=1; sum/cout held stable; in_ready=0.
  - On out_ready high at an edge: out_valid<=0, go to IDLE.
  - sum/cout keep their last value until the next capture clears sum.
- Latency: out_valid rises exactly NSEG edges after the accepting edge.
- Throughput: with in_valid and out_ready tied high, one result every NSEG+2 cycles.
- No overlap:
  - A new operand is never accepted in the same cycle that a result is consumed.
  - in_valid during RUN/DONE is ignored and must be held by the source.
- Arithmetic: unsigned, modulo 2^WIDTH in sum, overflow in cout; {cout,sum} == row_a+row_b+cin.
- Boundary conditions:
  - NSEG==1: RUN lasts a single cycle.
  - Carry chain across all segments (all-propagate) resolves correctly through the carry register.
  - seg_idx never exceeds NSEG-1; it is not used in IDLE/DONE.
- Reset mid-operation (RUN or DONE): abandon the operation, return to reset values, and emit no partial result.
- Elaboration: WIDTH%SEG!=0 or SEG<1 must cause an elaboration error.

Test Plan:
- WIDTH=32, SEG=8; row_a=32'h12345678, row_b=32'h87654321, cin=0 -> after 4 edges out_valid=1, sum=32'h99999999, cout=0.
- Full carry ripple: row_a=32'hFFFFFFFF, row_b=32'h00000001, cin=0 -> sum=32'h00000000, cout=1; row_a=32'hFFFFFFFF, row_b=0, cin=1 -> same result.
- Zero case: row_a=0, row_b=0, cin=1 -> sum=32'h00000001, cout=0.
- Backpressure: out_ready low for 5 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0 throughout, in_valid pulse ignored.
- Result released on out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 segments of 32'hFFFFFFFF+1 -> outputs immediately 0, state IDLE, no out_valid.
- Next transaction after reset completes correctly.
- Streaming plus random: out_ready tied 1, in_valid tied 1 -> results every 6 cycles; 10k random operand sets, each matching {cout,sum} against row_a+row_b+cin.
